ram_copy_engine: RTL

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

---
 rtl/ram_copy_pkg.sv | 15 +
 rtl/ram_copy_engine.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_copy_pkg.sv
// Shared definitions for the RAM-to-RAM copy engine:
// FSM state encoding and default geometry.
package ram_copy_pkg;

   localparam int DW_DEF = 16;
   localparam int AW_DEF = 14;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// Copies len words inside a dual-port RAM: port 1 reads, port 2 writes
// one cycle later. Overlapping forward moves run descending (memmove).
module ram_copy_engine
   import ram_copy_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] addr1,
   output logic          w_en1,
   input  logic [DW-1:0] q1,
   output logic [AW-1:0] addr2,
   output logic [DW-1:0] data2,
   output logic          w_en2
);

   localparam logic [AW:0]   LIM   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] AONE  = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] addr1_q, addr1_d;
   logic [AW-1:0] addr2_q, addr2_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          desc_q, desc_d;
   logic          w_en2_q, w_en2_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [AW:0]   s_end, d_end;
   logic [AW-1:0] lm1;
   logic          bad, ovl;

   always_comb begin
      s_end = {1'b0, src_addr} + len;
      d_end = {1'b0, dst_addr} + len;
      bad   = (s_end > LIM) || (d_end > LIM);
      ovl   = (dst_addr > src_addr) && ({1'b0, dst_addr} < s_end);
      // modulo-2**AW is exact here: a legal request never wraps
      lm1   = len[AW-1:0] - AONE;

      state_d = state_q;
      addr1_d = addr1_q;
      addr2_d = addr2_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      desc_d  = desc_q;
      busy_d  = busy_q;
      w_en2_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad) begin
                  err_d = 1'b1;
               end else if (len == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
                  desc_d  = ovl;
                  cnt_d   = len;
                  addr1_d = ovl ? src_addr + lm1 : src_addr;
                  dst_d   = ovl ? dst_addr + lm1 : dst_addr;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               w_en2_d = 1'b1;
               addr2_d = dst_q;
               if (cnt_q == CONE) begin
                  state_d = S_DRAIN;
               end else begin
                  cnt_d   = cnt_q - CONE;
                  addr1_d = desc_q ? addr1_q - AONE : addr1_q + AONE;
                  dst_d   = desc_q ? dst_q - AONE : dst_q + AONE;
               end
            end
         end
         S_DRAIN: begin
            busy_d = 1'b0;
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr1_q <= '0;
         addr2_q <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         desc_q  <= 1'b0;
         w_en2_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         desc_q  <= desc_d;
         w_en2_q <= w_en2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign addr1 = addr1_q;
   assign w_en1 = 1'b0;
   assign addr2 = addr2_q;
   assign data2 = q1;
   assign w_en2 = w_en2_q;

endmodule
